// File: rtl/grad_cost_sched.sv
// grad_cost_sched: stream scheduler between the Sobel gradient stage and the
// matching-cost datapath. Holds a MAXD-deep left-gradient disparity window,
// a registered right gradient, and the column/row position of the presented
// pixel.
// Optional feature macro: GRAD_SCHED_PERF_EN adds the stall_cnt output.
module grad_cost_sched #(
  parameter int MAXD  = 256,
  parameter int W     = 11,
  parameter int IMG_W = 640,
  parameter int IMG_H = 480
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic                     in_sof,
  input  logic                     in_eol,
  input  logic [W-1:0]             ixl_in,
  input  logic [W-1:0]             iyl_in,
  input  logic [W-1:0]             ixr_in,
  input  logic [W-1:0]             iyr_in,
  output logic [W-1:0]             Ix_R,
  output logic [W-1:0]             Iy_R,
  output logic [MAXD*W-1:0]        Ix_L,
  output logic [MAXD*W-1:0]        Iy_L,
  output logic                     clken,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [$clog2(MAXD)-1:0]  dmax,
  output logic [$clog2(IMG_W)-1:0] out_col,
  output logic [$clog2(IMG_H)-1:0] out_row,
  output logic                     out_eof,
  output logic                     err
`ifdef GRAD_SCHED_PERF_EN
  ,
  output logic [31:0]              stall_cnt
`endif
);

  localparam int DW = $clog2(MAXD);
  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t        r_state;
  logic [CW-1:0] r_col;   // column expected for the next accepted pixel
  logic [RW-1:0] r_row;   // row expected for the next accepted pixel

  logic          w_accept;
  logic          w_take;
  logic          w_row_start;
  logic          w_last_col;
  logic          w_last_row;
  logic          w_last_pix;
  logic [CW-1:0] w_pix_col;
  logic [RW-1:0] w_pix_row;
  logic [DW-1:0] w_dmax;

  assign in_ready = (r_state != S_DONE) && (!out_valid || out_ready);
  assign w_accept = in_valid && in_ready;
  assign clken    = w_accept;

  // In IDLE only a start-of-frame pixel enters the pipeline; others are dropped.
  assign w_take = w_accept && ((r_state == S_RUN) || in_sof);

  // A start-of-frame pixel always sits at (0,0), also when it restarts a frame.
  assign w_pix_col   = in_sof ? '0 : r_col;
  assign w_pix_row   = in_sof ? '0 : r_row;
  assign w_row_start = (w_pix_col == '0);
  assign w_last_col  = (32'(w_pix_col) == 32'(IMG_W - 1));
  assign w_last_row  = (32'(w_pix_row) == 32'(IMG_H - 1));
  assign w_last_pix  = w_last_col && w_last_row;
  assign w_dmax      = (32'(w_pix_col) >= 32'(MAXD - 1)) ? DW'(MAXD - 1) : DW'(w_pix_col);

  // Disparity window: slot gi holds column x-gi of the current row only.
  for (genvar gi = 0; gi < MAXD; gi++) begin : g_slot
    logic [W-1:0] r_x;
    logic [W-1:0] r_y;
    if (gi == 0) begin : g_head
      // Newest column enters slot 0 on every taken pixel.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_x <= '0;
          r_y <= '0;
        end else if (w_take) begin
          r_x <= ixl_in;
          r_y <= iyl_in;
        end
      end
    end else begin : g_tail
      // Older slots shift, or clear at row start so rows never mix.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_x <= '0;
          r_y <= '0;
        end else if (w_take) begin
          r_x <= w_row_start ? '0 : g_slot[gi-1].r_x;
          r_y <= w_row_start ? '0 : g_slot[gi-1].r_y;
        end
      end
    end
    assign Ix_L[gi*W +: W] = r_x;
    assign Iy_L[gi*W +: W] = r_y;
  end

  // Frame FSM with position tracking, framing checks and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_col     <= '0;
      r_row     <= '0;
      out_valid <= 1'b0;
      Ix_R      <= '0;
      Iy_R      <= '0;
      dmax      <= '0;
      out_col   <= '0;
      out_row   <= '0;
      out_eof   <= 1'b0;
      err       <= 1'b0;
    end else if (w_take) begin
      out_valid <= 1'b1;
      Ix_R      <= ixr_in;
      Iy_R      <= iyr_in;
      dmax      <= w_dmax;
      out_col   <= w_pix_col;
      out_row   <= w_pix_row;
      out_eof   <= w_last_pix;
      // Counters, not in_eol, decide where the row wraps.
      r_col     <= w_last_col ? '0 : w_pix_col + CW'(1);
      r_row     <= w_last_col ? (w_last_row ? '0 : w_pix_row + RW'(1)) : w_pix_row;
      if ((r_state == S_RUN) && in_sof) begin
        err <= 1'b1;
      end
      if (in_eol != w_last_col) begin
        err <= 1'b1;
      end
      r_state <= w_last_pix ? S_DONE : S_RUN;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
      if (r_state == S_DONE) begin
        r_state <= S_IDLE;
      end
    end
  end

`ifdef GRAD_SCHED_PERF_EN
  // Count back-pressure cycles, saturating; restarts with each new frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (w_accept && in_sof) begin
      stall_cnt <= '0;
    end else if (out_valid && !out_ready && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_grad_cost_sched.sv
// Randomized self-checking bench for grad_cost_sched (MAXD=4, 8x2 frames).
// A queue-based row history model predicts every output each cycle.
module tb_grad_cost_sched;

  localparam int MAXD  = 4;
  localparam int W     = 11;
  localparam int IMG_W = 8;
  localparam int IMG_H = 2;

  logic                     clk = 1'b0;
  logic                     rst;
  logic                     in_valid;
  logic                     in_ready;
  logic                     in_sof;
  logic                     in_eol;
  logic [W-1:0]             ixl_in;
  logic [W-1:0]             iyl_in;
  logic [W-1:0]             ixr_in;
  logic [W-1:0]             iyr_in;
  logic [W-1:0]             Ix_R;
  logic [W-1:0]             Iy_R;
  logic [MAXD*W-1:0]        Ix_L;
  logic [MAXD*W-1:0]        Iy_L;
  logic                     clken;
  logic                     out_valid;
  logic                     out_ready;
  logic [$clog2(MAXD)-1:0]  dmax;
  logic [$clog2(IMG_W)-1:0] out_col;
  logic [$clog2(IMG_H)-1:0] out_row;
  logic                     out_eof;
  logic                     err;
`ifdef GRAD_SCHED_PERF_EN
  logic [31:0]              stall_cnt;
`endif

  grad_cost_sched #(.MAXD(MAXD), .W(W), .IMG_W(IMG_W), .IMG_H(IMG_H)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_sof(in_sof), .in_eol(in_eol),
    .ixl_in(ixl_in), .iyl_in(iyl_in), .ixr_in(ixr_in), .iyr_in(iyr_in),
    .Ix_R(Ix_R), .Iy_R(Iy_R), .Ix_L(Ix_L), .Iy_L(Iy_L),
    .clken(clken), .out_valid(out_valid), .out_ready(out_ready),
    .dmax(dmax), .out_col(out_col), .out_row(out_row), .out_eof(out_eof), .err(err)
`ifdef GRAD_SCHED_PERF_EN
    , .stall_cnt(stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: frame mode 0=idle 1=run 2=done, next position, and
  // the current row's left gradients newest-first.
  int          m_mode;
  int          m_col;
  int          m_row;
  bit          m_ov;
  bit          m_err;
  logic [W-1:0] qx[$];
  logic [W-1:0] qy[$];
  logic [W-1:0] exp_ixr;
  logic [W-1:0] exp_iyr;
  int          exp_col;
  int          exp_row;
  int          exp_dmax;
  bit          exp_eof;
  logic [31:0] exp_stall;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s got=%0h want=%0h at %0t", tag, got, want, $time);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_col = 0; m_row = 0; m_ov = 0; m_err = 0;
    qx.delete(); qy.delete();
    exp_ixr = '0; exp_iyr = '0;
    exp_col = 0; exp_row = 0; exp_dmax = 0; exp_eof = 0;
    exp_stall = '0;
  endtask

  task automatic check_outputs();
    check("out_valid", out_valid, m_ov);
    check("err", err, m_err);
    check("Ix_R", Ix_R, exp_ixr);
    check("Iy_R", Iy_R, exp_iyr);
    check("out_col", out_col, exp_col);
    check("out_row", out_row, exp_row);
    check("dmax", dmax, exp_dmax);
    check("out_eof", out_eof, exp_eof);
    for (int d = 0; d < MAXD; d++) begin
      check($sformatf("Ix_L%0d", d), Ix_L[d*W +: W], (d < qx.size()) ? qx[d] : '0);
      check($sformatf("Iy_L%0d", d), Iy_L[d*W +: W], (d < qy.size()) ? qy[d] : '0);
    end
`ifdef GRAD_SCHED_PERF_EN
    check("stall_cnt", stall_cnt, exp_stall);
`endif
  endtask

  // Advance the model across one rising edge given the current inputs.
  task automatic model_step(input bit acc);
    int pc;
    int pr;
    if (m_ov && !out_ready && exp_stall != 32'hffff_ffff) exp_stall++;
    if (acc && in_sof) exp_stall = '0;
    if (acc && (m_mode == 1 || in_sof)) begin
      if (m_mode == 1 && in_sof) m_err = 1;
      pc = in_sof ? 0 : m_col;
      pr = in_sof ? 0 : m_row;
      if (in_eol != (pc == IMG_W - 1)) m_err = 1;
      if (pc == 0) begin
        qx.delete();
        qy.delete();
      end
      qx.push_front(ixl_in);
      qy.push_front(iyl_in);
      if (qx.size() > MAXD) begin
        void'(qx.pop_back());
        void'(qy.pop_back());
      end
      exp_ixr  = ixr_in;
      exp_iyr  = iyr_in;
      exp_col  = pc;
      exp_row  = pr;
      exp_dmax = (pc < MAXD - 1) ? pc : MAXD - 1;
      exp_eof  = (pc == IMG_W - 1) && (pr == IMG_H - 1);
      m_col    = (pc + 1) % IMG_W;
      m_row    = (pc == IMG_W - 1) ? (pr + 1) % IMG_H : pr;
      m_mode   = exp_eof ? 2 : 1;
      m_ov     = 1;
      $display("txn col=%0d row=%0d sof=%0b eol=%0b ixl=%0h eof=%0b", pc, pr, in_sof, in_eol, ixl_in, exp_eof);
    end else if (m_ov && out_ready) begin
      m_ov = 0;
      if (m_mode == 2) m_mode = 0;
    end
  endtask

  // err_pct > 0 injects wrong in_eol and mid-frame in_sof.
  task automatic run_cycles(input int n, input int err_pct);
    bit acc;
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      check_outputs();
      in_valid  = ($urandom_range(0, 99) < 70);
      out_ready = ($urandom_range(0, 99) < 65);
      ixl_in    = W'($urandom);
      iyl_in    = W'($urandom);
      ixr_in    = W'($urandom);
      iyr_in    = W'($urandom);
      if (m_mode == 1) begin
        in_sof = (err_pct > 0) && ($urandom_range(0, 99) < err_pct);
        in_eol = (m_col == IMG_W - 1);
        if ((err_pct > 0) && ($urandom_range(0, 99) < err_pct)) in_eol = ~in_eol;
      end else begin
        in_sof = ($urandom_range(0, 99) < 75);
        in_eol = 1'b0;
      end
      #1;
      check("in_ready", in_ready, (m_mode != 2) && (!m_ov || out_ready));
      acc = in_valid && (m_mode != 2) && (!m_ov || out_ready);
      check("clken", clken, acc);
      model_step(acc);
    end
  endtask

  task automatic mid_reset();
    @(negedge clk);
    in_valid  = 1'b1;
    out_ready = 1'b1;
    rst       = 1'b1;
    #1;
    model_reset();
    check_outputs();
    check("in_ready_rst", in_ready, 1'b1);
    in_valid = 1'b0;
    @(negedge clk);
    check_outputs();
    check("in_ready_rst2", in_ready, 1'b1);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_sof = 1'b0; in_eol = 1'b0; out_ready = 1'b0;
    ixl_in = '0; iyl_in = '0; ixr_in = '0; iyr_in = '0;
    model_reset();
    @(negedge clk);
    check_outputs();
    check("in_ready_init", in_ready, 1'b1);
    rst = 1'b0;
    run_cycles(500, 0);
    run_cycles(500, 3);
    mid_reset();
    run_cycles(400, 0);
    @(negedge clk);
    check_outputs();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
